// File: rtl/regfile_sb_if.sv
// regfile_sb_if
// Bundle of the register-file signals shared by decode and writeback.
// The slave modport faces the register file and the master modport faces
// the pipeline that drives it.
//   rd_addr    : packed read addresses, port i at [i*AW +: AW]
//   rd_data    : packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy    : per-port "source still pending" flag
//   wr_en/wr_addr/wr_data : writeback retire
//   iss_en/iss_addr       : decode reserves a destination
//   stall      : RAW or WAW hazard towards decode
//   busy_count : number of registers currently reserved
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                stall;
  logic [AW:0]         busy_count;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, stall, busy_count
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, stall, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb
// General-purpose register file with a per-register scoreboard and an
// optional same-cycle write bypass. Decode reads sources and reserves
// destinations; writeback retires results and clears reservations.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears registers and reservations
//   bus   : regfile_sb_if slave modport (read ports, writeback, issue,
//           stall and busy_count)
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          reset,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] LP_NREGS = (AW+1)'(NREGS);

  logic [XLEN-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busyCount;

  logic            w_wrOk;
  logic            w_issOk;
  logic            w_inc;
  logic            w_dec;
  logic            w_issWaw;
  logic [NRD*XLEN-1:0] w_rdData;
  logic [NRD-1:0]  w_rdBusy;

  // An address is usable when it names a real register and is not the
  // hard-wired zero register; reads of unusable addresses return 0/not busy.
  function automatic logic isWritable(input logic [AW-1:0] addr);
    return ({1'b0, addr} < LP_NREGS) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign w_wrOk  = bus.wr_en  && isWritable(bus.wr_addr);
  assign w_issOk = bus.iss_en && isWritable(bus.iss_addr);

  // The counter moves only when a busy bit actually flips. A write and an
  // issue to the same register leave the bit set, so nothing is retired.
  assign w_inc = w_issOk && !r_busy[bus.iss_addr];
  assign w_dec = w_wrOk && r_busy[bus.wr_addr] &&
                 !(w_issOk && (bus.iss_addr == bus.wr_addr));

  assign w_issWaw = w_issOk && r_busy[bus.iss_addr];

  // Register and scoreboard state. The issue assignment comes after the
  // write so that a new producer keeps the register reserved.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy      <= '0;
      r_busyCount <= '0;
    end else begin
      if (w_wrOk) begin
        r_regs[bus.wr_addr] <= bus.wr_data;
        r_busy[bus.wr_addr] <= 1'b0;
      end
      if (w_issOk) begin
        r_busy[bus.iss_addr] <= 1'b1;
      end
      case ({w_inc, w_dec})
        2'b10:   r_busyCount <= r_busyCount + 1'b1;
        2'b01:   r_busyCount <= r_busyCount - 1'b1;
        default: r_busyCount <= r_busyCount;
      endcase
    end
  end

  // Combinational read ports. A matching writeback this cycle supplies the
  // data directly and also satisfies the pending reservation.
  for (genvar g = 0; g < NRD; g++) begin : gRead
    logic [AW-1:0]   w_addr;
    logic            w_readOk;
    logic            w_bypHit;
    logic [XLEN-1:0] w_portData;
    logic            w_portBusy;

    assign w_addr     = bus.rd_addr[g*AW +: AW];
    assign w_readOk   = isWritable(w_addr);
    assign w_bypHit   = (BYPASS != 0) && w_wrOk && (bus.wr_addr == w_addr);
    assign w_portData = !w_readOk ? '0 :
                        w_bypHit  ? bus.wr_data : r_regs[w_addr];
    assign w_portBusy = w_readOk && !w_bypHit && r_busy[w_addr];

    assign w_rdData[g*XLEN +: XLEN] = w_portData;
    assign w_rdBusy[g]              = w_portBusy;
  end

  // Outputs are forced quiet while reset is held so decode sees a clean
  // register file for the whole reset window, not just after it.
  assign bus.rd_data    = reset ? '0 : w_rdData;
  assign bus.rd_busy    = reset ? '0 : w_rdBusy;
  assign bus.stall      = !reset && ((|w_rdBusy) || w_issWaw);
  assign bus.busy_count = reset ? '0 : r_busyCount;
endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              tReset   = 1'b1;
  logic              tWrEn    = 1'b0;
  logic [AW-1:0]     tWrAddr  = '0;
  logic [XLEN-1:0]   tWrData  = '0;
  logic              tIssEn   = 1'b0;
  logic [AW-1:0]     tIssAddr = '0;
  logic [NRD*AW-1:0] tRdAddr  = '0;

  int tests = 0;
  int fails = 0;

  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) busB ();
  regfile_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) busN ();

  assign busB.rd_addr  = tRdAddr;
  assign busB.wr_en    = tWrEn;
  assign busB.wr_addr  = tWrAddr;
  assign busB.wr_data  = tWrData;
  assign busB.iss_en   = tIssEn;
  assign busB.iss_addr = tIssAddr;
  assign busN.rd_addr  = tRdAddr;
  assign busN.wr_en    = tWrEn;
  assign busN.wr_addr  = tWrAddr;
  assign busN.wr_data  = tWrData;
  assign busN.iss_en   = tIssEn;
  assign busN.iss_addr = tIssAddr;

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
    dutB (.clk(clk), .reset(tReset), .bus(busB));
  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .BYPASS(0))
    dutN (.clk(clk), .reset(tReset), .bus(busN));

  // Reference model: architectural contents plus a set of reserved registers.
  logic [XLEN-1:0] mRegs [NREGS];
  bit   [NREGS-1:0] mBusy;

  always @(posedge clk) begin
    if (tReset) begin
      for (int i = 0; i < NREGS; i++) mRegs[i] = '0;
      mBusy = '0;
    end else begin
      if (tWrEn && tWrAddr != 0) begin
        mRegs[tWrAddr] = tWrData;
        mBusy[tWrAddr] = 1'b0;
      end
      if (tIssEn && tIssAddr != 0) mBusy[tIssAddr] = 1'b1;
    end
  end

  function automatic logic [XLEN-1:0] expData(input bit byp, input logic [AW-1:0] a);
    if (tReset || a == 0) return '0;
    if (byp && tWrEn && tWrAddr == a) return tWrData;
    return mRegs[a];
  endfunction

  function automatic logic expBusy(input bit byp, input logic [AW-1:0] a);
    if (tReset || a == 0) return 1'b0;
    if (byp && tWrEn && tWrAddr == a) return 1'b0;
    return mBusy[a];
  endfunction

  function automatic logic expStall(input bit byp);
    if (tReset) return 1'b0;
    return expBusy(byp, tRdAddr[0 +: AW]) || expBusy(byp, tRdAddr[AW +: AW]) ||
           (tIssEn && tIssAddr != 0 && mBusy[tIssAddr]);
  endfunction

  function automatic int expCount();
    if (tReset) return 0;
    return $countones(mBusy);
  endfunction

  task automatic doCheck(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NRD*XLEN-1:0] d;
    logic [NRD-1:0]      b;
    logic                s;
    logic [AW:0]         c;
    string               tag;
    for (int v = 0; v < 2; v++) begin
      d   = (v == 1) ? busB.rd_data    : busN.rd_data;
      b   = (v == 1) ? busB.rd_busy    : busN.rd_busy;
      s   = (v == 1) ? busB.stall      : busN.stall;
      c   = (v == 1) ? busB.busy_count : busN.busy_count;
      tag = (v == 1) ? "byp" : "nobyp";
      for (int p = 0; p < NRD; p++) begin
        doCheck($sformatf("%s rd_data[%0d]", tag, p), 64'(d[p*XLEN +: XLEN]),
                64'(expData(v == 1, tRdAddr[p*AW +: AW])));
        doCheck($sformatf("%s rd_busy[%0d]", tag, p), 64'(b[p]),
                64'(expBusy(v == 1, tRdAddr[p*AW +: AW])));
      end
      doCheck($sformatf("%s stall", tag), 64'(s), 64'(expStall(v == 1)));
      doCheck($sformatf("%s busy_count", tag), 64'(c), 64'(expCount()));
    end
  endtask

  // Every cycle, mid-period, both builds are compared against the model.
  always @(negedge clk) checkOutput();

  task automatic applyStimulus(input logic rst, input logic wrEn, input logic [AW-1:0] wrAddr,
                               input logic [XLEN-1:0] wrData, input logic issEn,
                               input logic [AW-1:0] issAddr, input logic [AW-1:0] rd0,
                               input logic [AW-1:0] rd1);
    tReset   = rst;
    tWrEn    = wrEn;
    tWrAddr  = wrAddr;
    tWrData  = wrData;
    tIssEn   = issEn;
    tIssAddr = issAddr;
    tRdAddr  = {rd1, rd0};
  endtask

  task automatic cycleEnd();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rndAddr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREGS-1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset held with a write and an issue pending: both must be discarded.
    applyStimulus(1, 1, 5, 32'hFFFF_FFFF, 1, 6, 5, 6);
    cycleEnd();
    @(negedge clk);
    doCheck("lit reset stall", 64'(busB.stall), 64'd0);
    doCheck("lit reset data", 64'(busB.rd_data), 64'd0);
    cycleEnd();

    for (int a = 0; a < NREGS; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, AW'(a), AW'(NREGS-1-a));
      @(negedge clk);
      doCheck("lit post-reset data", 64'(busB.rd_data), 64'd0);
      doCheck("lit post-reset busy", 64'(busB.rd_busy | busN.rd_busy), 64'd0);
      doCheck("lit post-reset count", 64'(busB.busy_count), 64'd0);
      cycleEnd();
    end

    applyStimulus(0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5);
    @(negedge clk);
    doCheck("lit bypass x5 port1", 64'(busB.rd_data[63:32]), 64'hDEAD_BEEF);
    doCheck("lit nobypass x5 old", 64'(busN.rd_data[63:32]), 64'd0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 5);
    @(negedge clk);
    doCheck("lit nobypass x5 next", 64'(busN.rd_data[63:32]), 64'hDEAD_BEEF);
    cycleEnd();

    applyStimulus(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    doCheck("lit x0 reads zero", 64'(busB.rd_data), 64'd0);
    cycleEnd();

    applyStimulus(0, 0, 0, 0, 1, 7, 0, 0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    doCheck("lit x7 rd_busy", 64'(busB.rd_busy), 64'd1);
    doCheck("lit x7 stall", 64'(busB.stall), 64'd1);
    doCheck("lit x7 count", 64'(busB.busy_count), 64'd1);
    cycleEnd();
    cycleEnd();
    applyStimulus(0, 1, 7, 32'hA5A5_A5A5, 0, 0, 7, 0);
    @(negedge clk);
    doCheck("lit x7 bypass data", 64'(busB.rd_data[31:0]), 64'hA5A5_A5A5);
    doCheck("lit x7 bypass busy", 64'(busB.rd_busy), 64'd0);
    doCheck("lit x7 bypass stall", 64'(busB.stall), 64'd0);
    doCheck("lit x7 nobypass busy", 64'(busN.rd_busy), 64'd1);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 7, 0);
    @(negedge clk);
    doCheck("lit x7 count cleared", 64'(busB.busy_count), 64'd0);
    doCheck("lit x7 nobypass data", 64'(busN.rd_data[31:0]), 64'hA5A5_A5A5);
    cycleEnd();

    applyStimulus(0, 1, 3, 32'h11, 1, 3, 3, 0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    @(negedge clk);
    doCheck("lit x3 data", 64'(busB.rd_data[31:0]), 64'h11);
    doCheck("lit x3 still busy", 64'(busB.rd_busy), 64'd1);
    doCheck("lit x3 count", 64'(busB.busy_count), 64'd1);
    cycleEnd();
    applyStimulus(0, 1, 3, 32'h22, 0, 0, 0, 0);
    cycleEnd();

    applyStimulus(0, 0, 0, 0, 1, 9, 0, 0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 1, 9, 0, 0);
    @(negedge clk);
    doCheck("lit x9 waw stall", 64'(busB.stall), 64'd1);
    doCheck("lit x9 waw no rd_busy", 64'(busB.rd_busy), 64'd0);
    cycleEnd();
    applyStimulus(1, 0, 0, 0, 0, 0, 9, 0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0);
    @(negedge clk);
    doCheck("lit x9 count after reset", 64'(busB.busy_count), 64'd0);
    doCheck("lit x9 stall after reset", 64'(busB.stall), 64'd0);
    doCheck("lit x9 data after reset", 64'(busB.rd_data[31:0]), 64'd0);
    cycleEnd();

    applyStimulus(0, 1, 4, 32'h55, 0, 0, 4, 0);
    @(negedge clk);
    doCheck("lit nobypass x4 same cycle", 64'(busN.rd_data[31:0]), 64'd0);
    cycleEnd();
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    @(negedge clk);
    doCheck("lit nobypass x4 next cycle", 64'(busN.rd_data[31:0]), 64'h55);
    cycleEnd();

    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), rndAddr(),
                    $urandom(), 1'($urandom_range(0, 1)), rndAddr(), rndAddr(), rndAddr());
      cycleEnd();
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
